// File: rtl/uart_rx_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_pkg                                                      |
// | Purpose  : Shared types and constants for the UART receive buffer slice.    |
// |            cap_state_e : capture handshake FSM states                       |
// |            STAT_W      : width of the optional statistics counters          |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package uart_rx_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        WAIT_LOW = 2'd2
    } cap_state_e;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_buffer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_fifo                                                        |
// | Purpose  : Single-clock FIFO with registered storage and head-of-queue      |
// |            read data (first-word fall-through).                             |
// | Ports    : clk, rst_n         clock / async active-low reset               |
// |            push, push_data   write request and byte                        |
// |            pop               read request (ignored while empty)            |
// |            rd_data           head entry                                    |
// |            full, empty       occupancy flags                               |
// |            count             occupancy, 0..DEPTH                           |
// | Params   : DEPTH (power of two, >=2), DATA_W                                |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w+1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w+1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_count == c_full);
    assign empty = (r_count == '0);
    assign count = r_count;

    // A pop only counts when there is something to pop; a push into a full
    // FIFO is still accepted when the same edge frees a slot.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Storage is reset so rd_data reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so wrap is the natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_buffer                                                   |
// | Purpose  : Captures bytes from async_receiver via its ready/clear handshake,|
// |            buffers them in a FIFO and presents them on a valid/ready        |
// |            stream. Bytes lost to a full FIFO set a sticky overflow flag.    |
// | Ports    : clk, rst_n            clock / async active-low reset            |
// |            rx_ready, rx_data    receiver byte-ready and byte               |
// |            rx_clear             one-cycle acknowledge to the receiver      |
// |            rd_valid, rd_ready   consumer stream handshake                  |
// |            rd_data              head-of-FIFO byte                          |
// |            count                FIFO occupancy                             |
// |            overflow, ovf_clr    sticky drop flag and its clear             |
// |            rx_total, rx_dropped statistics (zero unless enabled)           |
// | Config   : define UART_RX_BUF_STATS_EN to build saturating byte counters.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_buffer
    import uart_rx_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_ready,
    input  logic [DATA_W-1:0]        rx_data,
    output logic                     rx_clear,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [STAT_W-1:0]        rx_total,
    output logic [STAT_W-1:0]        rx_dropped
);

    cap_state_e r_state;
    cap_state_e w_state_next;
    logic       w_capture;
    logic       w_rx_clear;
    logic       w_full;
    logic       w_empty;
    logic       w_drop;
    logic       r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // WAIT_LOW blocks re-capture until the receiver has dropped rx_ready, so
    // a byte whose ready flag lingers is never taken twice.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_rx_clear   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = CLEAR;
                end
            end
            CLEAR: begin
                w_rx_clear   = 1'b1;
                w_state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!rx_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // rx_clear decodes the state register directly, so it drops as soon as
    // reset forces the state back to IDLE.
    assign rx_clear = w_rx_clear;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_capture),
        .push_data (rx_data),
        .pop       (rd_ready),
        .rd_data   (rd_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (count)
    );

    assign rd_valid = ~w_empty;

    // Full implies non-empty, so rd_ready alone means a pop frees a slot.
    assign w_drop = w_capture & w_full & ~rd_ready;

    // Setting has priority over clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

`ifdef UART_RX_BUF_STATS_EN
    logic [STAT_W-1:0] r_rx_total;
    logic [STAT_W-1:0] r_rx_dropped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_total   <= '0;
            r_rx_dropped <= '0;
        end else begin
            if (w_capture && (r_rx_total != '1)) begin
                r_rx_total <= r_rx_total + STAT_W'(1);
            end
            if (w_drop && (r_rx_dropped != '1)) begin
                r_rx_dropped <= r_rx_dropped + STAT_W'(1);
            end
        end
    end

    assign rx_total   = r_rx_total;
    assign rx_dropped = r_rx_dropped;
`else
    assign rx_total   = '0;
    assign rx_dropped = '0;
`endif

endmodule : uart_rx_buffer
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_rx_buffer                                                |
// | Purpose  : Self-checking bench for uart_rx_buffer (DEPTH=16, DATA_W=8).     |
// |            Per-cycle vector table plus directed multi-cycle sequences.     |
// |            Honours UART_RX_BUF_STATS_EN for the statistics outputs.        |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_rx_buffer;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

`ifdef UART_RX_BUF_STATS_EN
    localparam bit c_stats = 1'b1;
`else
    localparam bit c_stats = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_clear;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        count;
    logic              overflow;
    logic              ovf_clr;
    logic [15:0]       rx_total;
    logic [15:0]       rx_dropped;

    int total = 0;
    int bad   = 0;

    uart_rx_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_clear   (rx_clear),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .count      (count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .rx_total   (rx_total),
        .rx_dropped (rx_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One row = inputs for one clock edge and the outputs expected after it.
    typedef struct {
        logic       rdy;
        logic [7:0] d;
        logic       rrdy;
        logic       oclr;
        logic       clr;
        logic       vld;
        logic       ovf;
        logic [4:0] cnt;
        logic       chkd;
        logic [7:0] rdat;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_ready = 1'b0;
        rx_data  = '0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Behaves like async_receiver: ready stays up until rx_clear is seen.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rx_clear && n < 4);
        if (!rx_clear) begin
            total++;
            bad++;
            $display("FAIL send_byte timeout: no rx_clear for 0x%0h within %0d cycles", b, n);
        end
        rx_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop_check(input logic [7:0] exp);
        chk("pop_valid", 32'(rd_valid), 32'd1);
        chk("pop_data", 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        int pulses;

        // rdy  d      rrdy oclr  clr vld ovf cnt  chkd rdat
        vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 8'h00};
        vt[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 8'h41};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h41};
        vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h41};
        vt[4]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 8'h41};
        vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h42};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00};
        vt[7]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 8'h55};
        vt[8]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h55};
        vt[9]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h55};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h55};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h55};
        vt[12] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 8'h66};

        // Reset state
        do_reset();
        chk("reset_outputs", {rx_clear, rd_valid, overflow, count, rd_data},
            32'h0);
        chk("reset_stats", {rx_total, rx_dropped}, 32'h0);

        // Per-cycle vector table
        for (int i = 0; i < 13; i++) begin
            rx_ready = vt[i].rdy;
            rx_data  = vt[i].d;
            rd_ready = vt[i].rrdy;
            ovf_clr  = vt[i].oclr;
            tick();
            chk($sformatf("vec%0d", i),
                32'({rx_clear, rd_valid, overflow, count, (vt[i].chkd ? rd_data : 8'h00)}),
                32'({vt[i].clr, vt[i].vld, vt[i].ovf, vt[i].cnt, (vt[i].chkd ? vt[i].rdat : 8'h00)}));
        end
        rx_ready = 1'b0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;

        // rx_ready held high 20 cycles: a single capture and a single pulse
        do_reset();
        rx_data  = 8'h77;
        rx_ready = 1'b1;
        pulses   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_clear) pulses++;
        end
        chk("held_ready_pulses", 32'(pulses), 32'd1);
        chk("held_ready_count", 32'(count), 32'd1);
        rx_ready = 1'b0;
        tick();
        tick();
        chk("held_ready_data", 32'(rd_data), 32'h77);

        // 17 bytes into a 16-deep FIFO with no reads
        do_reset();
        for (int i = 0; i < 17; i++) send_byte(8'(i));
        chk("ovf_fill_count", 32'(count), 32'd16);
        chk("ovf_fill_flag", 32'(overflow), 32'd1);
        chk("ovf_rx_total", 32'(rx_total), c_stats ? 32'd17 : 32'd0);
        chk("ovf_rx_dropped", 32'(rx_dropped), c_stats ? 32'd1 : 32'd0);
        for (int i = 0; i < 16; i++) pop_check(8'(i));
        chk("ovf_drain_valid", 32'(rd_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Push into a full FIFO while popping in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("full_pp_pre_data", 32'(rd_data), 32'h00);
        rx_data  = 8'hAA;
        rx_ready = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("full_pp_state", 32'({rx_clear, overflow, count}), 32'({1'b1, 1'b0, 5'd16}));
        rx_ready = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 16; i++) pop_check(8'(i));
        pop_check(8'hAA);
        chk("full_pp_empty", 32'({rd_valid, count}), 32'h0);
        chk("full_pp_stats_drop", 32'(rx_dropped), 32'd0);

        // ovf_clr coincident with a drop: set wins, then clear alone works
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        rx_data  = 8'hBB;
        rx_ready = 1'b1;
        ovf_clr  = 1'b1;
        tick();
        chk("set_wins", 32'(overflow), 32'd1);
        rx_ready = 1'b0;
        tick();
        chk("clr_alone", 32'(overflow), 32'd0);
        ovf_clr = 1'b0;
        tick();
        chk("clr_head_kept", 32'({count, rd_data}), 32'({5'd16, 8'h10}));

        // Reset asserted while in CLEAR with bytes buffered
        do_reset();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        rx_data  = 8'h99;
        rx_ready = 1'b1;
        tick();
        chk("rst_mid_pre", 32'({rx_clear, count}), 32'({1'b1, 5'd4}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async", 32'({rx_clear, rd_valid, count}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_recapture", 32'({rx_clear, rd_valid, count, rd_data}),
            32'({1'b1, 1'b1, 5'd1, 8'h99}));
        rx_ready = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx_buffer
`default_nettype wire
